// File: rtl/logic_cell_pkg.sv
// logic_cell_pkg: shared constants and address-map helpers for logic_cell_k.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Config byte layout, in terms of K and NOUT:
//   [tables: NOUT * 2^K/8 bytes, little-endian per output]
//   [K input selectors][CE selector][SR selector][NOUT mode bytes]
package logic_cell_pkg;

  // Mode byte bit positions
  localparam int MODE_ASYNC = 0;
  localparam int MODE_CE    = 1;
  localparam int MODE_SR    = 2;
  localparam int MODE_SRVAL = 3;
  localparam int MODE_CARRY = 4;

  // LUT0 reset table: passes LUT input 0 through
  localparam logic [7:0] RST_TABLE = 8'hAA;

  function automatic int tbl_bytes(input int k);
    return (1 << k) / 8;
  endfunction

  function automatic int tbl_base(input int k, input int i);
    return i * tbl_bytes(k);
  endfunction

  function automatic int sel_base(input int k, input int nout);
    return nout * tbl_bytes(k);
  endfunction

  function automatic int ce_addr(input int k, input int nout);
    return sel_base(k, nout) + k;
  endfunction

  function automatic int sr_addr(input int k, input int nout);
    return ce_addr(k, nout) + 1;
  endfunction

  function automatic int mode_base(input int k, input int nout);
    return sr_addr(k, nout) + 1;
  endfunction

  function automatic int ncfg(input int k, input int nout);
    return mode_base(k, nout) + nout;
  endfunction

  // Selector byte: bit idx_w is the side (1 = in_y), low idx_w bits the index
  function automatic logic sel_side(input logic [7:0] s, input int idx_w);
    return |((s >> idx_w) & 8'h01);
  endfunction

  function automatic logic [7:0] sel_make(input logic side, input int idx, input int idx_w);
    return 8'(idx) | (8'(side) << idx_w);
  endfunction

endpackage

// File: rtl/logic_cell_k_mux.sv
// cell_input_mux: picks one bit of in_x/in_y according to a selector byte.
// Latency: combinational.
// Backpressure: none.
//
// Ports: sel_i selector byte, x_i/y_i routing buses, bit_o selected bit.
module cell_input_mux
  import logic_cell_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic [7:0]      sel_i,
  input  logic [IN_W-1:0] x_i,
  input  logic [IN_W-1:0] y_i,
  output logic            bit_o
);

  localparam int IDX_W = $clog2(IN_W);

  logic [IDX_W-1:0] idx;
  logic             side;

  // Bits above the side bit are stored by the owner but ignored here
  assign idx   = sel_i[IDX_W-1:0];
  assign side  = sel_side(sel_i, IDX_W);
  assign bit_o = side ? y_i[idx] : x_i[idx];

endmodule

// File: rtl/logic_cell_k.sv
// logic_cell_k: K-input, NOUT-output LUT cell with double-buffered byte config.
// Latency: out is combinational (async mode) or 1 clk (flop); cfg_out 1 clk.
// Backpressure: none; config writes and commits are accepted every cycle.
//
// Ports: clk, rst_n (async active-low); in_x/in_y routing buses; out cell
// outputs; cfg_in/cfg_addr/cfg_we shadow write; cfg_commit shadow->active;
// cfg_out registered readback of active[cfg_addr].
// Optional: define LOGIC_CELL_CARRY_EN to add cin/cout and the carry mode bit.
module logic_cell_k
  import logic_cell_pkg::*;
#(
  parameter int INDEX  = 0,
  parameter int K      = 4,
  parameter int NOUT   = 2,
  parameter int IN_W   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_x,
  input  logic [IN_W-1:0]   in_y,
  output logic [NOUT-1:0]   out,
  input  logic [7:0]        cfg_in,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_we,
  input  logic              cfg_commit,
  output logic [7:0]        cfg_out
`ifdef LOGIC_CELL_CARRY_EN
  ,
  input  logic              cin,
  output logic              cout
`endif
);

  localparam int IDX_W  = $clog2(IN_W);
  localparam int TB     = tbl_bytes(K);
  localparam int NTBL   = 1 << K;
  localparam int SEL_B  = sel_base(K, NOUT);
  localparam int MODE_B = mode_base(K, NOUT);
  localparam int NCFG   = ncfg(K, NOUT);

  function automatic logic [7:0] rst_byte(input int a);
    if (a < TB) return RST_TABLE;
    if (a >= SEL_B && a < SEL_B + K) return sel_make(1'b0, (INDEX + a - SEL_B) % IN_W, IDX_W);
    return 8'h00;
  endfunction

  logic [7:0] shadow_q [NCFG];
  logic [7:0] shadow_d [NCFG];
  logic [7:0] active_q [NCFG];
  logic [7:0] cfg_out_q, cfg_out_d;

  // Forward this cycle's write into the shadow image so a simultaneous
  // commit picks it up.
  always_comb begin
    for (int a = 0; a < NCFG; a++) begin
      shadow_d[a] = shadow_q[a];
      if (cfg_we && cfg_addr == ADDR_W'(a)) shadow_d[a] = cfg_in;
    end
  end

  always_comb begin
    cfg_out_d = 8'h00;
    for (int a = 0; a < NCFG; a++) begin
      if (cfg_addr == ADDR_W'(a)) cfg_out_d = active_q[a];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NCFG; a++) begin
        shadow_q[a] <= rst_byte(a);
        active_q[a] <= rst_byte(a);
      end
      cfg_out_q <= 8'h00;
    end else begin
      for (int a = 0; a < NCFG; a++) begin
        shadow_q[a] <= shadow_d[a];
        if (cfg_commit) active_q[a] <= shadow_d[a];
      end
      cfg_out_q <= cfg_out_d;
    end
  end

  assign cfg_out = cfg_out_q;

  // Selector bytes are contiguous: K LUT inputs, then CE, then SR.
  logic [K+1:0] mux_bit;

  for (genvar g = 0; g < K + 2; g++) begin : g_mux
    cell_input_mux #(.IN_W(IN_W)) u_mux (
      .sel_i (active_q[SEL_B+g]),
      .x_i   (in_x),
      .y_i   (in_y),
      .bit_o (mux_bit[g])
    );
  end

  logic [K-1:0] lut_idx;
  logic         ce_bit;
  logic         sr_bit;

  assign lut_idx = mux_bit[K-1:0];
  assign ce_bit  = mux_bit[K];
  assign sr_bit  = mux_bit[K+1];

  logic [NOUT-1:0][NTBL-1:0] tbl;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_tbl
    for (genvar gj = 0; gj < TB; gj++) begin : g_byte
      assign tbl[gi][8*gj +: 8] = active_q[tbl_base(K, gi) + gj];
    end
  end

  logic [NOUT-1:0] lut;
  logic [NOUT-1:0] src;

  always_comb begin
    for (int i = 0; i < NOUT; i++) lut[i] = tbl[i][lut_idx];
  end

`ifdef LOGIC_CELL_CARRY_EN
  localparam int GEN_I = (NOUT >= 2) ? 1 : 0;

  logic carry_on;
  assign carry_on = active_q[MODE_B][MODE_CARRY];

  // out0 becomes the sum bit; lut0 is propagate, lut1 is generate
  always_comb begin
    src = lut;
    if (carry_on) src[0] = lut[0] ^ cin;
  end

  assign cout = carry_on & (lut[0] ? cin : lut[GEN_I]);
`else
  assign src = lut;
`endif

  logic [NOUT-1:0] flop_q, flop_d;

  // SR has priority over CE
  always_comb begin
    for (int i = 0; i < NOUT; i++) begin
      if (active_q[MODE_B+i][MODE_SR] && sr_bit)
        flop_d[i] = active_q[MODE_B+i][MODE_SRVAL];
      else if (!active_q[MODE_B+i][MODE_CE] || ce_bit)
        flop_d[i] = src[i];
      else
        flop_d[i] = flop_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flop_q <= '0;
    else        flop_q <= flop_d;
  end

  always_comb begin
    for (int i = 0; i < NOUT; i++)
      out[i] = active_q[MODE_B+i][MODE_ASYNC] ? src[i] : flop_q[i];
  end

endmodule

// File: tb/tb_logic_cell_k.sv
// tb_logic_cell_k: directed literal checks plus randomized traffic compared
// against a byte-array model of the cell every cycle.
module tb_logic_cell_k;

  localparam int K      = 4;
  localparam int NOUT   = 2;
  localparam int IN_W   = 8;
  localparam int ADDR_W = 4;
  localparam int INDEX  = 0;
  localparam int IDX_W  = 3;
  localparam int TB     = (1 << K) / 8;
  localparam int SB     = NOUT * TB;
  localparam int CEA    = SB + K;
  localparam int SRA    = CEA + 1;
  localparam int MB     = SRA + 1;
  localparam int NCFG   = MB + NOUT;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IN_W-1:0]   in_x, in_y;
  logic [NOUT-1:0]   out;
  logic [7:0]        cfg_in;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cfg_we, cfg_commit;
  logic [7:0]        cfg_out;
`ifdef LOGIC_CELL_CARRY_EN
  logic cin = 1'b0;
  logic cout;
`endif

  logic_cell_k #(.INDEX(INDEX), .K(K), .NOUT(NOUT), .IN_W(IN_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_x       (in_x),
    .in_y       (in_y),
    .out        (out),
    .cfg_in     (cfg_in),
    .cfg_addr   (cfg_addr),
    .cfg_we     (cfg_we),
    .cfg_commit (cfg_commit),
    .cfg_out    (cfg_out)
`ifdef LOGIC_CELL_CARRY_EN
    ,
    .cin        (cin),
    .cout       (cout)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]      m_sh [NCFG];
  logic [7:0]      m_ac [NCFG];
  logic [NOUT-1:0] m_fl;
  logic [7:0]      m_co;

  task automatic m_reset();
    for (int a = 0; a < NCFG; a++) begin
      logic [7:0] v;
      v = 8'h00;
      if (a < TB) v = 8'hAA;
      if (a >= SB && a < SB + K) v = 8'((INDEX + a - SB) % IN_W);
      m_sh[a] = v;
      m_ac[a] = v;
    end
    m_fl = '0;
    m_co = 8'h00;
  endtask

  function automatic logic in_bit(input logic [7:0] s);
    int idx;
    idx = int'(s) % IN_W;
    if (((int'(s) >> IDX_W) & 1) == 1) return in_y[idx];
    return in_x[idx];
  endfunction

  function automatic logic lut_bit(input int i);
    logic [63:0] t;
    int idx;
    t = '0;
    idx = 0;
    for (int j = 0; j < TB; j++) t = t | (64'(m_ac[i*TB+j]) << (8*j));
    for (int k = 0; k < K; k++) if (in_bit(m_ac[SB+k])) idx += (1 << k);
    return t[idx];
  endfunction

  function automatic logic [NOUT-1:0] m_out();
    logic [NOUT-1:0] v;
    for (int i = 0; i < NOUT; i++) v[i] = m_ac[MB+i][0] ? lut_bit(i) : m_fl[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      logic [NOUT-1:0] nf;
      for (int i = 0; i < NOUT; i++) begin
        logic [7:0] m;
        m = m_ac[MB+i];
        if (m[2] && in_bit(m_ac[SRA]))      nf[i] = m[3];
        else if (!m[1] || in_bit(m_ac[CEA])) nf[i] = lut_bit(i);
        else                                 nf[i] = m_fl[i];
      end
      m_co = (int'(cfg_addr) < NCFG) ? m_ac[cfg_addr] : 8'h00;
      if (cfg_we && int'(cfg_addr) < NCFG) m_sh[cfg_addr] = cfg_in;
      if (cfg_commit) for (int a = 0; a < NCFG; a++) m_ac[a] = m_sh[a];
      m_fl = nf;
    end
  end

  // Single compare process, sampling away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", 32'(out), 32'(m_out()));
      chk("model_cfg_out", 32'(cfg_out), 32'(m_co));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] d, input logic commit);
    cfg_we = 1'b1;
    cfg_addr = ADDR_W'(addr);
    cfg_in = d;
    cfg_commit = commit;
    tick();
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_x = 8'h01;
    in_y = 8'h00;
    cfg_in = 8'h00;
    cfg_addr = '0;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    repeat (2) tick();
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_cfg_out", 32'(cfg_out), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset config: LUT0 passes input 0, out[1] table is zero
    tick();
    chk("lut0_pass", 32'(out), 32'h1);
    for (int k = 0; k < K; k++) begin
      cfg_addr = ADDR_W'(SB + k);
      tick();
      chk("rb_sel", 32'(cfg_out), 32'(k));
    end

    // AND4 into shadow only; active still 0xAAAA (idx 7 -> 1)
    in_x = 8'h07;
    wr(0, 8'h00, 1'b0);
    wr(1, 8'h80, 1'b0);
    tick();
    chk("no_commit", 32'(out[0]), 32'h1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("and4_low", 32'(out[0]), 32'h0);
    in_x = 8'h0F;
    tick();
    chk("and4_high", 32'(out[0]), 32'h1);
    in_x = 8'h0E;
    tick();
    chk("and4_in0", 32'(out[0]), 32'h0);

    // Async mode: out0 follows inputs within the cycle
    wr(MB, 8'h01, 1'b1);
    in_x = 8'h0F;
    #1 chk("async_hi", 32'(out[0]), 32'h1);
    in_x = 8'h07;
    #1 chk("async_lo", 32'(out[0]), 32'h0);

    // CE from in_y[7]; mode write forwarded into same-cycle commit
    wr(CEA, 8'h0F, 1'b0);
    wr(MB, 8'h02, 1'b1);
    in_y = 8'h80;
    in_x = 8'h0F;
    tick();
    chk("ce_load", 32'(out[0]), 32'h1);
    in_y = 8'h00;
    in_x = 8'h00;
    tick();
    tick();
    chk("ce_hold", 32'(out[0]), 32'h1);
    in_y = 8'h80;
    tick();
    chk("ce_update", 32'(out[0]), 32'h0);

    // SR from in_y[0] beats CE low
    wr(SRA, 8'h08, 1'b0);
    wr(MB, 8'h0E, 1'b1);
    in_y = 8'h01;
    tick();
    chk("sr_beats_ce", 32'(out[0]), 32'h1);

    // Forwarded write+commit readback
    cfg_addr = ADDR_W'(MB);
    wr(MB, 8'h01, 1'b1);
    cfg_addr = ADDR_W'(MB);
    tick();
    chk("fwd_commit", 32'(cfg_out), 32'h01);
    wr(15, 8'h55, 1'b1);
    cfg_addr = 4'd15;
    tick();
    chk("oob_read", 32'(cfg_out), 32'h0);

    // Reset in the middle of configuration
    wr(2, 8'h77, 1'b0);
    cfg_addr = ADDR_W'(SRA);
    tick();
    chk("pre_rst_rb", 32'(cfg_out), 32'h08);
    rst_n = 1'b0;
    #1 chk("rst_async_cfg", 32'(cfg_out), 32'h0);
    tick();
    rst_n = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_addr = 4'd2;
    tick();
    chk("shadow_lost", 32'(cfg_out), 32'h0);
    cfg_addr = 4'd0;
    tick();
    chk("rst_table", 32'(cfg_out), 32'hAA);
    cfg_addr = ADDR_W'(SB + 3);
    tick();
    chk("rst_sel3", 32'(cfg_out), 32'h03);

    // Randomized traffic, checked by the model process
    for (int n = 0; n < 3000; n++) begin
      in_x = 8'($urandom);
      in_y = 8'($urandom);
      cfg_we = ($urandom_range(0, 2) == 0);
      cfg_addr = ADDR_W'($urandom_range(0, 15));
      cfg_in = 8'($urandom);
      cfg_commit = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 400) != 0);
      tick();
    end
    rst_n = 1'b1;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
